piso_br_stream: RTL
===================

// Module: piso_br_stream
// PURPOSE
//  Parametrised parallel-in/serial-out shifter with programmable bit period
//  (clocks per bit), selectable bit order and a valid/ready input handshake.
//  A one-word holding buffer allows back-to-back words to stream with no idle
//  gap. Sits between a word producer (FIFO/register bank) and a serial line driver.
// PARAMETERS
//  WIDTH      8   data word width in bits (>=2)
//  DIV_W      8   width of the bit-period divider input
//  MSB_FIRST  1   1: din[WIDTH-1] shifted first; 0: din[0] first
//  IDLE_LVL   1   value driven on dout when no word is being shifted
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  din        in   WIDTH    parallel data word
//  din_valid  in   1        din holds a word to accept
//  din_ready  out  1        block can accept a word this cycle
//  div        in   DIV_W    clocks per bit; 0 treated as 1; sampled at word load
//  dout       out  1        serial data
//  dout_valid out  1        dout carries a data bit this cycle
//  busy       out  1        shifter active or holding buffer occupied
//  done       out  1        1-cycle pulse: final clock of a word's last bit
// BEHAVIOUR
//  Reset (rst_n=0, async): shifter empty, buffer empty, bit/div counters 0,
//   dout=IDLE_LVL, dout_valid=0, busy=0, done=0, din_ready=1 once released.
//  Transfer occurs at a rising edge where din_valid & din_ready.
//  din_ready = !buf_full (registered); independent of din_valid.
//  States: IDLE (shifter empty), SHIFT (shifting word, buffer empty),
//   SHIFT_FULL (shifting word, buffer holds next word).
//  IDLE + transfer at edge T: word and div loaded straight into shifter;
//   first bit on dout, dout_valid=1 from just after T -> SHIFT. No extra latency.
//  SHIFT + transfer: word stored in buffer -> SHIFT_FULL; din_ready drops.
//  Each bit is held exactly max(div,1) clocks; div is latched per word, so
//   changes mid-word take effect at the next word load.
//  End of last bit (edge closing its final clock):
//   buffer full  -> buffer moves to shifter, new div latched, next word's first
//                  bit on dout at once (gapless) -> SHIFT; din_ready rises.
//   buffer empty -> IDLE; dout=IDLE_LVL, dout_valid=0.
//   Simultaneous end-of-word in SHIFT and transfer: word goes directly to
//   shifter (gapless) -> SHIFT.
//  done=1 during final clock of bit WIDTH-1 of every word, including back-to-back words.
//  busy = (state != IDLE).
//  Bit counter: 0..WIDTH-1, width $clog2(WIDTH); div counter DIV_W bits, counts
//   0..max(div,1)-1, no overflow possible.
//  Bit order fixed by MSB_FIRST; no runtime mode change.
//  rst_n low mid-word: word and buffer discarded immediately, outputs to reset
//   values asynchronously; no done pulse.
//  din_valid while din_ready=0: ignored; producer holds din/din_valid.
// TESTING
//  1) MSB_FIRST=1, div=2, din=8'hA5 single word -> dout 1,0,1,0,0,1,0,1 each
//     2 clks, dout_valid 16 clks, done at clk 16, then dout=IDLE_LVL, busy=0.
//  2) Two words 8'hF0, 8'h0F back-to-back, div=3 -> 48 contiguous dout_valid
//     clks, no gap, din_ready low from 2nd accept to 1st word's end, 2 done pulses.
//  3) div=0 with din=8'h81 -> behaves as div=1: 8 clks, dout 1,0,0,0,0,0,0,1.
//  4) MSB_FIRST=0, div=1, din=8'h01 -> dout 1 then seven 0s.
//  5) rst_n pulsed low at bit 3 of 8'hFF (div=4) -> dout=IDLE_LVL,
//     dout_valid=0, din_ready=1 after release; no done.
//  6) div changed 2->5 mid-word -> current word stays at 2 clks/bit,
//     next word 5 clks/bit.

Source files
------------

// File: rtl/piso_br_stream.sv
// ============================================================================
// Module  : piso_br_stream
// Brief   : Parallel-in/serial-out shifter with programmable clocks-per-bit,
//           fixed bit order and a one-word holding buffer for gapless streaming.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_br_stream #(
  parameter int WIDTH     = 8,
  parameter int DIV_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [DIV_W-1:0] div,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] c_LAST_BIT = BW'(WIDTH - 1);
  localparam logic [BW-1:0] c_PEN_BIT  = BW'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SHIFT      = 2'd1,
    ST_SHIFT_FULL = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_buf;
  logic [BW-1:0]    r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] r_div_rld;
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_done;
  logic             r_din_ready;

  logic             w_xfer;
  logic             w_shifting;
  logic             w_bit_end;
  logic             w_word_end;
  logic             w_load;
  logic [WIDTH-1:0] w_load_word;
  logic             w_load_first;
  logic [DIV_W-1:0] w_div_rld;
  logic [WIDTH-1:0] w_sh_adv;
  logic             w_next_bit;

  assign w_xfer     = din_valid & r_din_ready;
  assign w_shifting = (r_state != ST_IDLE);
  // The divider counts down from max(div,1)-1, so a bit ends when it reaches 0.
  assign w_bit_end  = (r_div_cnt == '0);
  assign w_word_end = w_shifting & w_bit_end & (r_bit_cnt == c_LAST_BIT);

  // A new word enters the shifter from idle, or at a word boundary from the
  // buffer (if occupied) or straight from the input (gapless pass-through).
  assign w_load = ((r_state == ST_IDLE) & w_xfer) |
                  (w_word_end & ((r_state == ST_SHIFT_FULL) | w_xfer));

  assign w_load_word  = (r_state == ST_SHIFT_FULL) ? r_buf : din;
  assign w_load_first = MSB_FIRST ? w_load_word[WIDTH-1] : w_load_word[0];
  assign w_div_rld    = (div == '0) ? '0 : div - DIV_W'(1);
  assign w_sh_adv     = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
  assign w_next_bit   = MSB_FIRST ? r_sh[WIDTH-2] : r_sh[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sh         <= '0;
      r_buf        <= '0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_div_rld    <= '0;
      r_dout       <= IDLE_LVL;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_din_ready  <= 1'b1;
    end else if (w_load) begin
      r_state      <= ST_SHIFT;
      r_sh         <= w_load_word;
      r_dout       <= w_load_first;
      r_dout_valid <= 1'b1;
      r_bit_cnt    <= '0;
      r_div_cnt    <= w_div_rld;
      r_div_rld    <= w_div_rld;
      r_done       <= 1'b0;
      r_din_ready  <= 1'b1;
    end else if (!w_shifting) begin
      r_done <= 1'b0;
    end else if (w_word_end) begin
      r_state      <= ST_IDLE;
      r_dout       <= IDLE_LVL;
      r_dout_valid <= 1'b0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_done       <= 1'b0;
    end else begin
      // done is registered one clock early so it coincides with the final clock.
      if (w_bit_end) begin
        r_sh      <= w_sh_adv;
        r_dout    <= w_next_bit;
        r_bit_cnt <= r_bit_cnt + BW'(1);
        r_div_cnt <= r_div_rld;
        r_done    <= (r_bit_cnt == c_PEN_BIT) & (r_div_rld == '0);
      end else begin
        r_div_cnt <= r_div_cnt - DIV_W'(1);
        r_done    <= (r_bit_cnt == c_LAST_BIT) & (r_div_cnt == DIV_W'(1));
      end
      if (w_xfer) begin
        r_buf       <= din;
        r_din_ready <= 1'b0;
        r_state     <= ST_SHIFT_FULL;
      end
    end
  end

  assign din_ready  = r_din_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign done       = r_done;
  assign busy       = w_shifting;

endmodule

`default_nettype wire
